// File: rtl/lstm_stream_pkg.sv
// Shared types and constants for the LSTM y-sample streaming path.
package lstm_stream_pkg;

    localparam int Y_WIDTH = 16;
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // One buffered y sample, tagged with its end-of-sequence marker.
    typedef struct packed {
        logic               last;
        logic [Y_WIDTH-1:0] data;
    } y_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; the head entry is presented combinationally
// from registered storage, so a word written in cycle N is visible at N+1.
module sync_fifo_fwft #(
    parameter type DATA_T = logic [7:0],
    parameter int  DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  DATA_T         push_data,
    input  logic          pop,
    output DATA_T         rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    DATA_T         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_data = empty ? DATA_T'('0) : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/lstm_y_stream_packer.sv
// Packs the LSTM y_out pulse stream into AXI4-Stream packets of frame_len samples,
// buffering through a FIFO and counting samples lost to overflow.
module lstm_y_stream_packer
    import lstm_stream_pkg::*;
#(
    parameter int WIDTH      = Y_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 16,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic [WIDTH-1:0]     y_in,
    input  logic                 y_in_valid,
    output logic [WIDTH-1:0]     m_tdata,
    output logic                 m_tlast,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic [15:0]          drop_count,
    input  logic                 clr_overflow
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [LEN_WIDTH-1:0] fcnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cur_len;
    logic                 sample_ev;
    logic                 sample_last;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;
    y_word_t              wr_word;
    y_word_t              head_word;

    assign sample_ev = y_in_valid && enable;

    // The length is sampled on the first sample of a frame; later changes wait for the next frame.
    always_comb begin
        cur_len = len_q;
        if (fcnt == '0) begin
            cur_len = (frame_len == '0) ? LEN_ONE : frame_len;
        end
    end

    assign sample_last = (fcnt == (cur_len - LEN_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt  <= '0;
            len_q <= LEN_ONE;
        end else if (!enable) begin
            fcnt <= '0;
        end else if (sample_ev) begin
            if (fcnt == '0) begin
                len_q <= cur_len;
            end
            fcnt <= sample_last ? '0 : fcnt + LEN_ONE;
        end
    end

    always_comb begin
        wr_word      = '0;
        wr_word.last = sample_last;
        wr_word.data = y_in;
    end

    // Stream handshake: a beat transfers on a cycle with m_tvalid && m_tready; while
    // m_tvalid is high and m_tready low, m_tdata/m_tlast hold their values.
    sync_fifo_fwft #(
        .DATA_T (y_word_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sample_ev),
        .push_data (wr_word),
        .pop       (m_tready),
        .rd_data   (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = head_word.data;
    assign m_tlast  = head_word.last;

    // A full FIFO means a valid head, so m_tready alone decides whether space frees up.
    assign drop = sample_ev && fifo_full && !m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_count <= 16'd1;
            end else if (drop_count != DROP_CNT_MAX) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule
